gps_ack_sched: RTL and testbench

//  Sequences the gps_ack2 acquisition engine across a set of PRNs, one PRN per search.
//  For each PRN: starts the engine and tracks the strongest correlation over all

---
 rtl/gps_ack_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_gps_ack_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_ack_sched.sv
`default_nettype none
// ============================================================================
// Module   : gps_ack_sched
// Purpose  : Sweeps the gps_ack2 acquisition engine over a mask of PRNs, one
//            search per PRN. Tracks the strongest |I|+|Q| bin of each search,
//            compares it against a threshold and emits one result record per
//            PRN on a valid/ready port.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            start, abort             - sweep control pulses from host
//            prn_mask, threshold      - sweep configuration
//            busy, done               - sweep status
//            eng_start, eng_prn       - engine command
//            eng_corr_complete, eng_search_complete, eng_code_phase,
//            eng_code_frac, eng_doppler, eng_i, eng_q - engine bin results
//            res_valid, res_ready, res_prn, res_detect, res_timeout,
//            res_peak, res_code_phase, res_code_frac, res_doppler - result
// Revision : 1.0 - initial release
// ============================================================================
module gps_ack_sched #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16000000,
    parameter int          PRN_MIN        = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] prn_mask,
    input  logic [12:0] threshold,
    output logic        busy,
    output logic        done,
    output logic        eng_start,
    output logic [5:0]  eng_prn,
    input  logic        eng_corr_complete,
    input  logic        eng_search_complete,
    input  logic [9:0]  eng_code_phase,
    input  logic [4:0]  eng_code_frac,
    input  logic [15:0] eng_doppler,
    input  logic [11:0] eng_i,
    input  logic [11:0] eng_q,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [5:0]  res_prn,
    output logic        res_detect,
    output logic        res_timeout,
    output logic [12:0] res_peak,
    output logic [9:0]  res_code_phase,
    output logic [4:0]  res_code_frac,
    output logic [15:0] res_doppler
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SCAN   = 3'd1;
    localparam logic [2:0] c_ST_START  = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_REPORT = 3'd4;
    localparam logic [2:0] c_ST_FIN    = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_mask;
    logic        r_busy;
    logic        r_done;
    logic        r_eng_start;
    logic [5:0]  r_eng_prn;
    logic [23:0] r_timer;
    logic [12:0] r_peak;
    logic [9:0]  r_phase;
    logic [4:0]  r_frac;
    logic [15:0] r_dop;
    logic        r_res_valid;
    logic [5:0]  r_res_prn;
    logic        r_res_detect;
    logic        r_res_timeout;

    logic [11:0] w_abs_i;
    logic [11:0] w_abs_q;
    logic [12:0] w_mag;
    logic        w_take;
    logic [12:0] w_peak_nxt;
    logic        w_found;
    logic [4:0]  w_idx;
    logic [5:0]  w_prn;
    logic [23:0] w_timer_nxt;
    logic        w_timeout;

    // Two's complement magnitude; -2048 maps to 12'h800 = 2048 unsigned,
    // so the 13-bit sum never overflows (max 4096).
    assign w_abs_i = eng_i[11] ? (~eng_i + 12'd1) : eng_i;
    assign w_abs_q = eng_q[11] ? (~eng_q + 12'd1) : eng_q;
    assign w_mag   = {1'b0, w_abs_i} + {1'b0, w_abs_q};

    // Strict compare: on a tie the earlier bin stays as the peak.
    assign w_take     = eng_corr_complete && (w_mag > r_peak);
    assign w_peak_nxt = w_take ? w_mag : r_peak;

    // Timer counts WAIT cycles; the search expires on the cycle whose
    // incremented count reaches the limit.
    assign w_timer_nxt = r_timer + 24'd1;
    assign w_timeout   = (w_timer_nxt == TIMEOUT_CYCLES);

    // Lowest set bit of the remaining mask: scanning downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_found = 1'b1;
                w_idx   = 5'(i);
            end
        end
    end

    assign w_prn = 6'(PRN_MIN) + {1'b0, w_idx};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_mask        <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_eng_start   <= 1'b0;
            r_eng_prn     <= 6'd0;
            r_timer       <= 24'd0;
            r_peak        <= 13'd0;
            r_phase       <= 10'd0;
            r_frac        <= 5'd0;
            r_dop         <= 16'd0;
            r_res_valid   <= 1'b0;
            r_res_prn     <= 6'd0;
            r_res_detect  <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            r_done      <= 1'b0;
            if (abort && r_busy) begin
                // Abort beats everything else; no done pulse is produced.
                r_state     <= c_ST_IDLE;
                r_busy      <= 1'b0;
                r_res_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start) begin
                            r_mask  <= prn_mask;
                            r_busy  <= 1'b1;
                            r_state <= c_ST_SCAN;
                        end
                    end
                    c_ST_SCAN: begin
                        if (w_found) begin
                            r_mask[w_idx] <= 1'b0;
                            r_eng_prn     <= w_prn;
                            r_eng_start   <= 1'b1;
                            r_state       <= c_ST_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_ST_FIN;
                        end
                    end
                    c_ST_START: begin
                        r_peak  <= 13'd0;
                        r_phase <= 10'd0;
                        r_frac  <= 5'd0;
                        r_dop   <= 16'd0;
                        r_timer <= 24'd0;
                        r_state <= c_ST_WAIT;
                    end
                    c_ST_WAIT: begin
                        r_timer <= w_timer_nxt;
                        if (w_take) begin
                            r_peak  <= w_mag;
                            r_phase <= eng_code_phase;
                            r_frac  <= eng_code_frac;
                            r_dop   <= eng_doppler;
                        end
                        // Completion wins over a coincident timeout; the bin
                        // arriving with it is already folded into w_peak_nxt.
                        if (eng_search_complete) begin
                            r_res_valid   <= 1'b1;
                            r_res_prn     <= r_eng_prn;
                            r_res_timeout <= 1'b0;
                            r_res_detect  <= (w_peak_nxt > threshold);
                            r_state       <= c_ST_REPORT;
                        end else if (w_timeout) begin
                            r_res_valid   <= 1'b1;
                            r_res_prn     <= r_eng_prn;
                            r_res_timeout <= 1'b1;
                            r_res_detect  <= 1'b0;
                            r_state       <= c_ST_REPORT;
                        end
                    end
                    c_ST_REPORT: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            r_state     <= c_ST_SCAN;
                        end
                    end
                    c_ST_FIN: begin
                        r_state <= c_ST_IDLE;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign eng_start      = r_eng_start;
    assign eng_prn        = r_eng_prn;
    assign res_valid      = r_res_valid;
    assign res_prn        = r_res_prn;
    assign res_detect     = r_res_detect;
    assign res_timeout    = r_res_timeout;
    assign res_peak       = r_peak;
    assign res_code_phase = r_phase;
    assign res_code_frac  = r_frac;
    assign res_doppler    = r_dop;

endmodule
`default_nettype wire

// File: tb/tb_gps_ack_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gps_ack_sched
// Purpose  : Self-checking bench for gps_ack_sched. Directed stimulus pushes
//            expected result records into a queue; a monitor pops and
//            compares on every res_valid & res_ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gps_ack_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [31:0] prn_mask;
    logic [12:0] threshold;
    logic        busy, done, eng_start;
    logic [5:0]  eng_prn;
    logic        eng_corr_complete, eng_search_complete;
    logic [9:0]  eng_code_phase;
    logic [4:0]  eng_code_frac;
    logic [15:0] eng_doppler;
    logic [11:0] eng_i, eng_q;
    logic        res_valid, res_ready;
    logic [5:0]  res_prn;
    logic        res_detect, res_timeout;
    logic [12:0] res_peak;
    logic [9:0]  res_code_phase;
    logic [4:0]  res_code_frac;
    logic [15:0] res_doppler;

    always #5 clk = ~clk;

    gps_ack_sched #(
        .TIMEOUT_CYCLES (24'd100),
        .PRN_MIN        (1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .abort               (abort),
        .prn_mask            (prn_mask),
        .threshold           (threshold),
        .busy                (busy),
        .done                (done),
        .eng_start           (eng_start),
        .eng_prn             (eng_prn),
        .eng_corr_complete   (eng_corr_complete),
        .eng_search_complete (eng_search_complete),
        .eng_code_phase      (eng_code_phase),
        .eng_code_frac       (eng_code_frac),
        .eng_doppler         (eng_doppler),
        .eng_i               (eng_i),
        .eng_q               (eng_q),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_prn             (res_prn),
        .res_detect          (res_detect),
        .res_timeout         (res_timeout),
        .res_peak            (res_peak),
        .res_code_phase      (res_code_phase),
        .res_code_frac       (res_code_frac),
        .res_doppler         (res_doppler)
    );

    typedef struct packed {
        logic [5:0]  prn;
        logic        det;
        logic        tmo;
        logic [12:0] peak;
        logic [9:0]  ph;
        logic [4:0]  fr;
        logic [15:0] dop;
    } rec_t;

    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    int   start_cnt = 0;

    logic [11:0] bi[8];
    logic [11:0] bq[8];

    always @(negedge clk) begin
        if (!rst && done)      done_cnt++;
        if (!rst && eng_start) start_cnt++;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        rec_t got, e;
        if (!rst && res_valid && res_ready) begin
            got = {res_prn, res_detect, res_timeout, res_peak,
                   res_code_phase, res_code_frac, res_doppler};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL record_unexpected: got %h, no record expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL record: got prn=%0d det=%0b tmo=%0b peak=%0d ph=%0d fr=%0d dop=%h, expected prn=%0d det=%0b tmo=%0b peak=%0d ph=%0d fr=%0d dop=%h",
                             got.prn, got.det, got.tmo, got.peak, got.ph, got.fr, got.dop,
                             e.prn, e.det, e.tmo, e.peak, e.ph, e.fr, e.dop);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_rec(input logic [5:0] prn, input logic det, input logic tmo,
                            input logic [12:0] peak, input logic [9:0] ph,
                            input logic [4:0] fr, input logic [15:0] dop);
        rec_t e;
        e.prn = prn; e.det = det; e.tmo = tmo; e.peak = peak;
        e.ph = ph; e.fr = fr; e.dop = dop;
        exp_q.push_back(e);
    endtask

    // Bin k carries phase 100+k, frac k+1, doppler 1000*k-2000.
    task automatic set_bin(input int k);
        eng_i          = bi[k];
        eng_q          = bq[k];
        eng_code_phase = 10'(100 + k);
        eng_code_frac  = 5'(k + 1);
        eng_doppler    = 16'(1000 * k - 2000);
    endtask

    task automatic pulse_start(input logic [31:0] m);
        @(posedge clk); #1;
        prn_mask = m;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic run_engine(input int n, input bit merge);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            set_bin(k);
            eng_corr_complete = 1'b1;
            if (merge && k == n - 1) eng_search_complete = 1'b1;
        end
        @(posedge clk); #1;
        eng_corr_complete = 1'b0;
        if (!merge) begin
            eng_search_complete = 1'b1;
            @(posedge clk); #1;
        end
        eng_search_complete = 1'b0;
    endtask

    task automatic wait_eng_start(input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (eng_start) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0, d0, n_hit;
        bit  stable, seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; prn_mask = 32'd0; threshold = 13'd0;
        eng_corr_complete = 1'b0; eng_search_complete = 1'b0;
        eng_code_phase = '0; eng_code_frac = '0; eng_doppler = '0;
        eng_i = '0; eng_q = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_eng_prn", 32'(eng_prn), 32'd0);
        chk("rst_res_peak", 32'(res_peak), 32'd0);

        // T1: single PRN, tie keeps first 300 bin
        threshold = 13'd200;
        bi[0] = 12'd10;  bq[0] = 12'd0;
        bi[1] = 12'hF9C; bq[1] = 12'd200;
        bi[2] = 12'd300; bq[2] = 12'd0;
        bi[3] = 12'd50;  bq[3] = 12'd0;
        bi[4] = 12'd20;  bq[4] = 12'd0;
        push_rec(6'd1, 1'b1, 1'b0, 13'd300, 10'd101, 5'd2, 16'hFC18);
        pulse_start(32'h0000_0001);
        @(negedge clk);
        chk("t1_lat_c1_eng_start", 32'(eng_start), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_lat_c2_eng_start", 32'(eng_start), 32'd1);
        chk("t1_eng_prn", 32'(eng_prn), 32'd1);
        run_engine(5, 1'b0);
        wait_done("t1_done");
        chk("t1_busy_after", 32'(busy), 32'd0);

        // T2: three PRNs, no detection at 4096; mask change after start ignored
        threshold = 13'd4096;
        bi[0] = 12'd100; bq[0] = 12'hFEC;
        bi[1] = 12'hFF9; bq[1] = 12'd3;
        push_rec(6'd1,  1'b0, 1'b0, 13'd120, 10'd100, 5'd1, 16'hF830);
        push_rec(6'd3,  1'b0, 1'b0, 13'd120, 10'd100, 5'd1, 16'hF830);
        push_rec(6'd32, 1'b0, 1'b0, 13'd120, 10'd100, 5'd1, 16'hF830);
        s0 = start_cnt;
        pulse_start(32'h8000_0005);
        prn_mask = 32'hFFFF_FFFF;
        wait_eng_start("t2_start1");
        chk("t2_prn1", 32'(eng_prn), 32'd1);
        run_engine(2, 1'b0);
        wait_eng_start("t2_start2");
        chk("t2_prn2", 32'(eng_prn), 32'd3);
        // A start pulse mid-sweep must not restart anything.
        start = 1'b1;
        run_engine(2, 1'b0);
        start = 1'b0;
        wait_eng_start("t2_start3");
        chk("t2_prn3", 32'(eng_prn), 32'd32);
        run_engine(2, 1'b0);
        wait_done("t2_done");
        chk("t2_eng_start_count", 32'(start_cnt - s0), 32'd3);

        // T3: empty mask
        s0 = start_cnt;
        pulse_start(32'd0);
        @(negedge clk);
        chk("t3_done_c1", 32'(done), 32'd0);
        chk("t3_busy_c1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t3_done_c2", 32'(done), 32'd1);
        chk("t3_busy_c2", 32'(busy), 32'd0);
        chk("t3_no_eng_start", 32'(start_cnt - s0), 32'd0);

        // T4: engine never completes -> timeout record 101 cycles after eng_start
        threshold = 13'd200;
        bi[0] = 12'd500; bq[0] = 12'd0;
        push_rec(6'd5, 1'b0, 1'b1, 13'd500, 10'd100, 5'd1, 16'hF830);
        pulse_start(32'h0000_0010);
        wait_eng_start("t4_start");
        n_hit = 0;
        for (int n = 1; n <= 200 && n_hit == 0; n++) begin
            @(negedge clk);
            if (res_valid) n_hit = n;
            if (n == 1) begin set_bin(0); eng_corr_complete = 1'b1; end
            if (n == 2) eng_corr_complete = 1'b0;
        end
        chk("t4_timeout_latency", 32'(n_hit), 32'd101);
        wait_done("t4_done");

        // T5: -2048/-2048 magnitude, corr and search complete together
        threshold = 13'd4000;
        bi[0] = 12'd1000; bq[0] = 12'd1000;
        bi[1] = 12'h800;  bq[1] = 12'h800;
        push_rec(6'd3, 1'b1, 1'b0, 13'd4096, 10'd101, 5'd2, 16'hFC18);
        pulse_start(32'h0000_0004);
        wait_eng_start("t5_start");
        run_engine(2, 1'b1);
        wait_done("t5_done");

        // T6: consumer back-pressure for 50 cycles
        threshold = 13'd0;
        bi[0] = 12'd5; bq[0] = 12'd5;
        push_rec(6'd2, 1'b1, 1'b0, 13'd10, 10'd100, 5'd1, 16'hF830);
        @(posedge clk); #1 res_ready = 1'b0;
        pulse_start(32'h0000_0002);
        wait_eng_start("t6_start");
        run_engine(1, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("t6_valid_seen", 32'(seen), 32'd1);
        s0 = start_cnt;
        stable = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!(res_valid && res_peak == 13'd10 && res_prn == 6'd2 &&
                  res_code_phase == 10'd100 && res_detect)) stable = 1'b0;
        end
        chk("t6_hold_stable", 32'(stable), 32'd1);
        chk("t6_no_eng_start", 32'(start_cnt - s0), 32'd0);
        @(posedge clk); #1 res_ready = 1'b1;
        wait_done("t6_done");

        // Abort mid-WAIT
        pulse_start(32'h0000_0003);
        wait_eng_start("ab_start");
        chk("ab_prn", 32'(eng_prn), 32'd1);
        @(posedge clk); #1 set_bin(0); eng_corr_complete = 1'b1;
        @(posedge clk); #1 eng_corr_complete = 1'b0; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_res_valid", 32'(res_valid), 32'd0);
        d0 = done_cnt;
        s0 = start_cnt;
        repeat (10) @(negedge clk);
        chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
        chk("ab_no_eng_start", 32'(start_cnt - s0), 32'd0);

        // New sweep accepted after abort
        bi[0] = 12'd100; bq[0] = 12'hFEC;
        bi[1] = 12'hFF9; bq[1] = 12'd3;
        push_rec(6'd1, 1'b1, 1'b0, 13'd120, 10'd100, 5'd1, 16'hF830);
        pulse_start(32'h0000_0001);
        wait_eng_start("ab_restart");
        chk("ab_restart_prn", 32'(eng_prn), 32'd1);
        run_engine(2, 1'b0);
        wait_done("ab_restart_done");

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("total_done_pulses", 32'(done_cnt), 32'd7);
        chk("total_eng_starts", 32'(start_cnt), 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
